// File: rtl/bist_pkg.sv
// Shared BIST definitions: analyzer FSM states and the default feedback
// polynomial used by both the lfsr pattern generator and the MISR.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPACT,
    ST_DONE
  } state_t;

  // x^4 + x + 1, taps excluding the x^4 term
  localparam logic [3:0] LFSR_POLY_DEFAULT = 4'b0011;

endpackage

// File: rtl/bist_misr_analyzer_misr_core.sv
// Multiple-input signature register: Galois-style shift with polynomial
// feedback, XORed with the incoming response word on each enabled cycle.
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(LFSR_POLY_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] signature,
  output logic [WIDTH-1:0] next_signature
);

  always_comb begin
    next_signature = {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? POLY : '0)
                   ^ data;
  end

  // load has priority so a restart always discards the coincident data word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signature <= '0;
    end else if (load) begin
      signature <= load_value;
    end else if (enable) begin
      signature <= next_signature;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST output response analyzer: compacts NPAT CUT responses into a MISR,
// then compares the final signature against the golden value.
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(LFSR_POLY_DEFAULT),
  parameter int unsigned       NPAT  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           seed,
  input  logic                       data_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [WIDTH-1:0]           golden,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [WIDTH-1:0]           signature,
  output logic [$clog2(NPAT+1)-1:0]  count
);

  localparam int unsigned CW = $clog2(NPAT + 1);

  state_t           state;
  logic             compact;
  logic             last;
  logic [WIDTH-1:0] next_signature;

  // start outranks data_valid in every state, so data is only taken mid-run
  assign compact = (state == ST_COMPACT) && data_valid && !start;
  assign last    = compact && (count == CW'(NPAT - 1));

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk            (clk),
    .rst            (rst),
    .load           (start),
    .load_value     (seed),
    .enable         (compact),
    .data           (data_in),
    .signature      (signature),
    .next_signature (next_signature)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (start) begin
      state <= ST_COMPACT;
      count <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (compact) begin
      count <= count + CW'(1);
      if (last) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (next_signature == golden);
      end
    end
  end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Scoreboard bench for bist_misr_analyzer: three instances (NPAT 3, 1, 15)
// share data inputs; expected run results are queued and checked on done.
module tb_bist_misr_analyzer;

  typedef struct {
    logic [3:0] sig;
    logic       pass;
    int         cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start3, start1, start15;
  logic [3:0] seed, din, golden;
  logic       dv;

  logic       busy3, done3, pass3;
  logic [3:0] sig3;
  logic [1:0] cnt3;
  logic       busy1, done1, pass1;
  logic [3:0] sig1;
  logic [0:0] cnt1;
  logic       busy15, done15, pass15;
  logic [3:0] sig15;
  logic [3:0] cnt15;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int s;
  exp_t sb3[$], sb1[$], sb15[$];
  logic d3_q = 1'b0, d1_q = 1'b0, d15_q = 1'b0;
  logic [3:0] lseq[15];
  logic [3:0] ref_sig;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bist_misr_analyzer #(.NPAT(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .seed(seed), .data_valid(dv),
    .data_in(din), .golden(golden), .busy(busy3), .done(done3),
    .pass(pass3), .signature(sig3), .count(cnt3));

  bist_misr_analyzer #(.NPAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed), .data_valid(dv),
    .data_in(din), .golden(golden), .busy(busy1), .done(done1),
    .pass(pass1), .signature(sig1), .count(cnt1));

  bist_misr_analyzer u15 (
    .clk(clk), .rst(rst), .start(start15), .seed(seed), .data_valid(dv),
    .data_in(din), .golden(golden), .busy(busy15), .done(done15),
    .pass(pass15), .signature(sig15), .count(cnt15));

  // Reference model of x^4+x+1 Galois step, written per bit
  function automatic logic [3:0] lfsr_next(input logic [3:0] st);
    return {st[2], st[1], st[0] ^ st[3], st[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input logic [3:0] sg, input logic p,
                      input int c, input int cy);
    exp_t e;
    e.sig = sg; e.pass = p; e.cnt = c; e.cyc = cy;
    case (which)
      0: sb3.push_back(e);
      1: sb1.push_back(e);
      default: sb15.push_back(e);
    endcase
  endtask

  task automatic mon(input int which, input logic [3:0] sg, input logic p, input int c);
    exp_t e;
    int   sz;
    case (which)
      0: sz = sb3.size();
      1: sz = sb1.size();
      default: sz = sb15.size();
    endcase
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: instance %0d got done with no expectation", which);
    end else begin
      case (which)
        0: e = sb3.pop_front();
        1: e = sb1.pop_front();
        default: e = sb15.pop_front();
      endcase
      chk($sformatf("done_sig[%0d]", which), 32'(sg), 32'(e.sig));
      chk($sformatf("done_pass[%0d]", which), 32'(p), 32'(e.pass));
      chk($sformatf("done_count[%0d]", which), 32'(c), 32'(e.cnt));
      chk($sformatf("done_cycle[%0d]", which), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (done3 && !d3_q) mon(0, sig3, pass3, int'(cnt3));
    if (done1 && !d1_q) mon(1, sig1, pass1, int'(cnt1));
    if (done15 && !d15_q) mon(2, sig15, pass15, int'(cnt15));
    d3_q = done3; d1_q = done1; d15_q = done15;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [3:0] d);
    dv = 1'b1; din = d;
    tick();
    dv = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dv = 1'b1; din = 4'hF; seed = 4'hF; golden = 4'hF;
    start3 = 1'b1; start1 = 1'b1; start15 = 1'b1;
    tick(); tick();
    chk("rst_sig", 32'(sig3), 0);
    chk("rst_count", 32'(cnt3), 0);
    chk("rst_flags3", 32'({busy3, done3, pass3}), 0);
    chk("rst_flags_other", 32'({busy1, done1, pass1, busy15, done15, pass15}), 0);
    #2 rst = 1'b1;
    start3 = 1'b0; start1 = 1'b0; start15 = 1'b0; dv = 1'b0;
    tick();
    chk("idle_after_rst", 32'({busy3, sig3}), 0);

    // basic compaction, pass
    seed = 4'h0; golden = 4'h3;
    start3 = 1'b1; tick(); start3 = 1'b0; s = cyc;
    chk("start_busy", 32'(busy3), 1);
    chk("start_count", 32'(cnt3), 0);
    push(0, 4'h3, 1'b1, 3, s + 3);
    sample(4'h1); chk("basic_sig1", 32'(sig3), 32'h1);
    sample(4'h2); chk("basic_sig2", 32'(sig3), 32'h0);
    sample(4'h3); chk("basic_sig3", 32'(sig3), 32'h3);

    // same responses, wrong golden
    golden = 4'h5;
    start3 = 1'b1; tick(); start3 = 1'b0; s = cyc;
    push(0, 4'h3, 1'b0, 3, s + 3);
    sample(4'h1); sample(4'h2); sample(4'h3);
    dv = 1'b1; din = 4'hF; tick(); dv = 1'b0;
    chk("done_frozen_sig", 32'(sig3), 32'h3);
    chk("done_frozen_count", 32'(cnt3), 3);

    // gaps of two idle cycles between responses
    golden = 4'h3;
    start3 = 1'b1; tick(); start3 = 1'b0; s = cyc;
    push(0, 4'h3, 1'b1, 3, s + 7);
    sample(4'h1); tick(); tick();
    sample(4'h2); tick(); tick();
    sample(4'h3);

    // feedback path with NPAT=1
    seed = 4'b1000; golden = 4'b0011;
    start1 = 1'b1; tick(); start1 = 1'b0; s = cyc;
    push(1, 4'b0011, 1'b1, 1, s + 1);
    sample(4'h0);

    // restart mid-run with coincident data
    seed = 4'h5; golden = 4'h4;
    start3 = 1'b1; tick(); start3 = 1'b0;
    sample(4'h1); chk("pre_restart_sig1", 32'(sig3), 32'hB);
    sample(4'h2); chk("pre_restart_sig2", 32'(sig3), 32'h7);
    seed = 4'h9; start3 = 1'b1; dv = 1'b1; din = 4'hF;
    tick(); start3 = 1'b0; dv = 1'b0; s = cyc;
    chk("restart_sig", 32'(sig3), 32'h9);
    chk("restart_count", 32'(cnt3), 0);
    chk("restart_busy", 32'(busy3), 1);
    push(0, 4'h4, 1'b1, 3, s + 3);
    sample(4'h0); sample(4'h0); sample(4'h0);

    // asynchronous abort mid-run
    seed = 4'h0; golden = 4'h0;
    start15 = 1'b1; tick(); start15 = 1'b0;
    sample(4'h3); sample(4'h6); sample(4'hC);
    #3 rst = 1'b0;
    #1;
    chk("abort_sig15", 32'(sig15), 0);
    chk("abort_count15", 32'(cnt15), 0);
    chk("abort_flags15", 32'({busy15, done15, pass15}), 0);
    chk("abort_others", 32'({done3, pass3, sig3, done1, pass1, sig1}), 0);
    #2 rst = 1'b1;
    tick();

    // start from IDLE masks coincident data
    seed = 4'h6; golden = 4'hD;
    start1 = 1'b1; dv = 1'b1; din = 4'hF;
    tick(); start1 = 1'b0; dv = 1'b0; s = cyc;
    chk("idle_start_sig", 32'(sig1), 32'h6);
    chk("idle_start_count", 32'(cnt1), 0);
    push(1, 4'hD, 1'b1, 1, s + 1);
    sample(4'h1);

    // full period with lfsr responses
    lseq[0] = 4'b0011;
    for (int i = 1; i < 15; i++) lseq[i] = lfsr_next(lseq[i-1]);
    ref_sig = 4'h0;
    for (int i = 0; i < 15; i++) ref_sig = lfsr_next(ref_sig) ^ lseq[i];
    seed = 4'h0; golden = ref_sig;
    start15 = 1'b1; tick(); start15 = 1'b0; s = cyc;
    push(2, ref_sig, 1'b1, 15, s + 15);
    for (int i = 0; i < 15; i++) sample(lseq[i]);

    tick(); tick(); tick();
    chk("sb3_drained", 32'(sb3.size()), 0);
    chk("sb1_drained", 32'(sb1.size()), 0);
    chk("sb15_drained", 32'(sb15.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
